// File: rtl/drone_mix_pkg.sv
// Shared definitions for the quad-X motor mixer: default widths, axis
// indices, mixer FSM states and the motor/axis sign matrix.
package drone_mix_pkg;

    localparam int DEF_IN_W    = 16;
    localparam int DEF_MOTOR_W = 11;

    localparam int NUM_AXES   = 4;
    localparam int NUM_MOTORS = 4;

    // Axis order in which the sample is stepped through the shared adder.
    typedef logic [1:0] axis_idx_t;
    localparam axis_idx_t AXIS_THROTTLE = 2'd0;
    localparam axis_idx_t AXIS_PITCH    = 2'd1;
    localparam axis_idx_t AXIS_ROLL     = 2'd2;
    localparam axis_idx_t AXIS_YAW      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SAT,
        ST_OUT
    } mix_state_t;

    // Row m (motor m+1), bit a (axis a): 1 = subtract the axis term, 0 = add.
    //   m1 = +T +P +R -Y   -> 4'b1000
    //   m2 = +T +P -R +Y   -> 4'b0100
    //   m3 = +T -P -R -Y   -> 4'b1110
    //   m4 = +T -P +R +Y   -> 4'b0010
    localparam logic [NUM_MOTORS-1:0][NUM_AXES-1:0] SUB_MATRIX = {
        4'b0010,   // m4
        4'b1110,   // m3
        4'b0100,   // m2
        4'b1000    // m1
    };

endpackage

// File: rtl/motor_saturate.sv
// Combinational clamp of one signed mixer accumulator into the unsigned
// motor command range, forced to the minimum command when disarmed.
module motor_saturate
    import drone_mix_pkg::*;
#(
    parameter int ACC_W     = DEF_IN_W + 2,
    parameter int MOTOR_W   = DEF_MOTOR_W,
    parameter int MOTOR_MIN = 0,
    parameter int MOTOR_MAX = 2000
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic                      armed,
    output logic        [MOTOR_W-1:0] cmd
);

    // Compare in a width that holds both the accumulator and the bounds as signed values.
    localparam int CMP_W = ((ACC_W > MOTOR_W) ? ACC_W : MOTOR_W) + 2;
    localparam logic signed [CMP_W-1:0] LO_BOUND = CMP_W'(MOTOR_MIN);
    localparam logic signed [CMP_W-1:0] HI_BOUND = CMP_W'(MOTOR_MAX);

    logic signed [CMP_W-1:0] acc_ext;

    assign acc_ext = {{(CMP_W - ACC_W){acc[ACC_W-1]}}, acc};

    // Clamp to [MOTOR_MIN, MOTOR_MAX]; disarmed always yields MOTOR_MIN.
    always_comb begin
        // NOTE: assigning the default first guarantees every path drives cmd,
        // so no latch is inferred.
        cmd = MOTOR_W'(MOTOR_MIN);
        if (armed) begin
            if (acc_ext > HI_BOUND) begin
                cmd = MOTOR_W'(MOTOR_MAX);
            end else if (acc_ext >= LO_BOUND) begin
                cmd = acc_ext[MOTOR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/motor_mix_scheduler.sv
// Time-multiplexed quad-X motor mixer. One sample is accepted per in_valid/
// in_ready handshake, its four axis terms are folded into four accumulators
// one axis per cycle, the results are clamped and presented together behind
// an out_valid/out_ready handshake.
// Optional link-loss watchdog: define MIXER_FAILSAFE_EN to add the
// FAILSAFE_CYCLES parameter and the failsafe output.
module motor_mix_scheduler
    import drone_mix_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int MOTOR_W   = DEF_MOTOR_W,
    parameter int MOTOR_MIN = 0,
    parameter int MOTOR_MAX = 2000
`ifdef MIXER_FAILSAFE_EN
    ,
    parameter int FAILSAFE_CYCLES = 1000000
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [IN_W-1:0]    throttle_offset,
    input  logic signed [IN_W-1:0]    pitch_offset,
    input  logic signed [IN_W-1:0]    roll_offset,
    input  logic signed [IN_W-1:0]    yaw_offset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      armed,
    output logic        [MOTOR_W-1:0] motor_1_cmd,
    output logic        [MOTOR_W-1:0] motor_2_cmd,
    output logic        [MOTOR_W-1:0] motor_3_cmd,
    output logic        [MOTOR_W-1:0] motor_4_cmd,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MIXER_FAILSAFE_EN
    ,
    output logic                      failsafe
`endif
);

    // Four signed terms summed/subtracted: two extra bits cannot overflow.
    localparam int ACC_W = IN_W + 2;
    localparam logic [MOTOR_W-1:0] CMD_MIN = MOTOR_W'(MOTOR_MIN);

    mix_state_t state, state_nxt;
    axis_idx_t  axis;
    logic       accept;

    logic signed [IN_W-1:0]  hold_t, hold_p, hold_r, hold_y;
    logic signed [IN_W-1:0]  axis_term;
    logic signed [ACC_W-1:0] term_ext;
    logic signed [ACC_W-1:0] acc     [NUM_MOTORS];
    logic        [MOTOR_W-1:0] sat_cmd [NUM_MOTORS];
    logic        [MOTOR_W-1:0] cmd     [NUM_MOTORS];

`ifdef MIXER_FAILSAFE_EN
    localparam int WD_W = $clog2(FAILSAFE_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(FAILSAFE_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            fs_trip;
`endif

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (axis == AXIS_YAW) state_nxt = ST_SAT;
            end
            ST_SAT: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the accepted sample; upstream may change its inputs afterwards.
    always_ff @(posedge clk) begin
        // NOTE: pure data holding registers carry no reset: they are always
        // written on accept before the accumulators read them.
        if (accept) begin
            hold_t <= throttle_offset;
            hold_p <= pitch_offset;
            hold_r <= roll_offset;
            hold_y <= yaw_offset;
        end
    end

    // Select the axis term fed to the shared add/subtract stage.
    always_comb begin
        axis_term = hold_t;
        unique case (axis)
            AXIS_THROTTLE: axis_term = hold_t;
            AXIS_PITCH:    axis_term = hold_p;
            AXIS_ROLL:     axis_term = hold_r;
            AXIS_YAW:      axis_term = hold_y;
            default:       axis_term = hold_t;
        endcase
    end

    assign term_ext = {{(ACC_W - IN_W){axis_term[IN_W-1]}}, axis_term};

    // Axis sequencing and per-motor accumulation following the sign matrix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis <= AXIS_THROTTLE;
            for (int m = 0; m < NUM_MOTORS; m++) acc[m] <= '0;
        end else if (accept) begin
            axis <= AXIS_THROTTLE;
            for (int m = 0; m < NUM_MOTORS; m++) acc[m] <= '0;
        end else if (state == ST_ACCUM) begin
            axis <= axis + 2'd1;
            for (int m = 0; m < NUM_MOTORS; m++) begin
                acc[m] <= SUB_MATRIX[m][axis] ? (acc[m] - term_ext)
                                              : (acc[m] + term_ext);
            end
        end
    end

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_sat
        motor_saturate #(
            .ACC_W     (ACC_W),
            .MOTOR_W   (MOTOR_W),
            .MOTOR_MIN (MOTOR_MIN),
            .MOTOR_MAX (MOTOR_MAX)
        ) u_sat (
            .acc   (acc[g]),
            .armed (armed),
            .cmd   (sat_cmd[g])
        );
    end

    // Command registers: loaded in SAT, held through and after the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NUM_MOTORS; m++) cmd[m] <= CMD_MIN;
        end else if (state == ST_SAT) begin
            for (int m = 0; m < NUM_MOTORS; m++) cmd[m] <= sat_cmd[m];
        end
`ifdef MIXER_FAILSAFE_EN
        else if (fs_trip) begin
            for (int m = 0; m < NUM_MOTORS; m++) cmd[m] <= CMD_MIN;
        end
`endif
    end

    assign motor_1_cmd = cmd[0];
    assign motor_2_cmd = cmd[1];
    assign motor_3_cmd = cmd[2];
    assign motor_4_cmd = cmd[3];

`ifdef MIXER_FAILSAFE_EN
    // Trip only while idle, so an in-flight sample is never cut short.
    assign fs_trip = (state == ST_IDLE) && (wd_cnt == WD_LIMIT) && !accept;

    // Link-loss watchdog: cleared by each accepted sample, saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (accept) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Failsafe flag: set on a trip, cleared by the next accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            failsafe <= 1'b0;
        end else if (accept) begin
            failsafe <= 1'b0;
        end else if (fs_trip) begin
            failsafe <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_motor_mix_scheduler.sv
// Self-checking bench for motor_mix_scheduler: directed mix, saturation,
// disarm, backpressure and mid-sequence reset cases, then randomized samples
// against an arithmetic reference model. With MIXER_FAILSAFE_EN defined the
// watchdog (FAILSAFE_CYCLES=50) is exercised as well.
`timescale 1ns/1ps
module tb_motor_mix_scheduler;

    localparam int IN_W      = 16;
    localparam int MOTOR_W   = 11;
    localparam int MOTOR_MIN = 0;
    localparam int MOTOR_MAX = 2000;
    localparam int LATENCY   = 6;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic signed [IN_W-1:0]   thr = '0, pit = '0, rol = '0, yaw = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     armed = 1'b0;
    logic        [MOTOR_W-1:0] m1, m2, m3, m4;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
`ifdef MIXER_FAILSAFE_EN
    logic                     failsafe;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_cmd [4];

    always #5 clk = ~clk;

    motor_mix_scheduler #(
        .IN_W      (IN_W),
        .MOTOR_W   (MOTOR_W),
        .MOTOR_MIN (MOTOR_MIN),
        .MOTOR_MAX (MOTOR_MAX)
`ifdef MIXER_FAILSAFE_EN
        ,
        .FAILSAFE_CYCLES (50)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .throttle_offset (thr),
        .pitch_offset    (pit),
        .roll_offset     (rol),
        .yaw_offset      (yaw),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .armed           (armed),
        .motor_1_cmd     (m1),
        .motor_2_cmd     (m2),
        .motor_3_cmd     (m3),
        .motor_4_cmd     (m4),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
`ifdef MIXER_FAILSAFE_EN
        ,
        .failsafe        (failsafe)
`endif
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: quad-X mixing equations, then clamp, then armed gate.
    task automatic model(input int t, input int p, input int r, input int y, input bit arm);
        int raw [4];
        raw[0] = t + p + r - y;
        raw[1] = t + p - r + y;
        raw[2] = t - p - r - y;
        raw[3] = t - p + r + y;
        for (int i = 0; i < 4; i++) begin
            if (!arm)                   exp_cmd[i] = MOTOR_MIN;
            else if (raw[i] < MOTOR_MIN) exp_cmd[i] = MOTOR_MIN;
            else if (raw[i] > MOTOR_MAX) exp_cmd[i] = MOTOR_MAX;
            else                        exp_cmd[i] = raw[i];
        end
    endtask

    task automatic check_cmds(input string tag);
        check({tag, "_m1"}, 32'(m1), exp_cmd[0]);
        check({tag, "_m2"}, 32'(m2), exp_cmd[1]);
        check({tag, "_m3"}, 32'(m3), exp_cmd[2]);
        check({tag, "_m4"}, 32'(m4), exp_cmd[3]);
    endtask

    task automatic drive(input int t, input int p, input int r, input int y);
        thr = 16'(t);
        pit = 16'(p);
        rol = 16'(r);
        yaw = 16'(y);
    endtask

    // Called at the first negedge after the accepting edge.
    task automatic wait_out(input string tag);
        int lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, LATENCY);
        check_cmds(tag);
    endtask

    task automatic run_sample(input string tag, input int t, input int p, input int r,
                              input int y, input bit arm, input int hold, input bit early);
        @(negedge clk);
        drive(t, p, r, y);
        armed    = arm;
        in_valid = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 1);
        model(t, p, r, y, arm);
        @(negedge clk);
        in_valid = 1'b0;
        // Inputs are free to change once accepted.
        drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
        check({tag, "_busy"}, 32'(in_ready), 0);
        if (early) out_ready = 1'b1;
        wait_out(tag);
        if (!early) begin
            repeat (hold) @(negedge clk);
            check({tag, "_held_ov"}, 32'(out_valid), 1);
            check_cmds({tag, "_held"});
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_ov"}, 32'(out_valid), 0);
        check({tag, "_post_rdy"}, 32'(in_ready), 1);
        check_cmds({tag, "_post"});
    endtask

    initial begin
        int t, p, r, y;
        logic signed [IN_W-1:0] r16;
`ifdef MIXER_FAILSAFE_EN
        int  wait_cyc;
        bit  saw_ov;
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) exp_cmd[i] = MOTOR_MIN;
        check_cmds("rst");
`ifdef MIXER_FAILSAFE_EN
        check("rst_failsafe", 32'(failsafe), 0);
`endif
        rst_n = 1'b1;

        // Directed cases.
        run_sample("nominal", 1000, 100, 50, 20, 1'b1, 0, 1'b0);
        run_sample("sat_hi", 1990, 100, 0, 0, 1'b1, 0, 1'b0);
        run_sample("sat_lo", 50, -100, 0, 0, 1'b1, 0, 1'b0);
        run_sample("disarm", 1500, 0, 0, 0, 1'b0, 2, 1'b0);
        run_sample("early_rdy", 700, -30, 45, -12, 1'b1, 0, 1'b1);

        // Backpressure: second sample offered while the first is still held.
        @(negedge clk);
        drive(1000, 100, 50, 20);
        armed    = 1'b1;
        in_valid = 1'b1;
        model(1000, 100, 50, 20, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("bp_a");
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                drive(400, 25, -60, 90);
                in_valid = 1'b1;
            end
            @(negedge clk);
            check($sformatf("bp_ov_%0d", c), 32'(out_valid), 1);
            check($sformatf("bp_rdy_%0d", c), 32'(in_ready), 0);
        end
        check_cmds("bp_stable");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_rdy", 32'(in_ready), 1);
        check_cmds("bp_after_hs");
        model(400, 25, -60, 90, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("bp_b");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of accumulation.
        @(negedge clk);
        drive(1200, 200, -80, 40);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 32'(out_valid), 0);
        check("mid_rst_rdy", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) exp_cmd[i] = MOTOR_MIN;
        check_cmds("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ov", 32'(out_valid), 0);
        check_cmds("after_rst");
        run_sample("after_rst_mix", 1000, 100, 50, 20, 1'b1, 0, 1'b0);

        // Randomized samples: alternate full-range and near-motor-range operands.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                r16 = 16'($urandom); t = r16;
                r16 = 16'($urandom); p = r16;
                r16 = 16'($urandom); r = r16;
                r16 = 16'($urandom); y = r16;
            end else begin
                t = int'($urandom_range(0, 3200)) - 600;
                p = int'($urandom_range(0, 1200)) - 600;
                r = int'($urandom_range(0, 1200)) - 600;
                y = int'($urandom_range(0, 1200)) - 600;
            end
            run_sample($sformatf("rnd%0d", i), t, p, r, y, ($urandom_range(0, 7) != 0),
                       int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0);
        end

`ifdef MIXER_FAILSAFE_EN
        // Link loss: no input after a nominal sample.
        run_sample("fs_pre", 1000, 100, 50, 20, 1'b1, 0, 1'b0);
        wait_cyc = 0;
        saw_ov   = 1'b0;
        while (!failsafe && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
            if (out_valid) saw_ov = 1'b1;
        end
        check("fs_flag", 32'(failsafe), 1);
        check("fs_no_ov", 32'(saw_ov), 0);
        for (int i = 0; i < 4; i++) exp_cmd[i] = MOTOR_MIN;
        check_cmds("fs_cmds");
        run_sample("fs_clear", 1000, 100, 50, 20, 1'b1, 0, 1'b0);
        check("fs_cleared", 32'(failsafe), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
